// File: rtl/keccak_pkg.sv
// Shared constants for the Keccak-f[1600] round sequencer: geometry, step
// indices and the sequencer state encoding.
package keccak_pkg;

    localparam int LANE_W     = 64;
    localparam int ADDR_W     = 5;
    localparam int NUM_ROUNDS = 24;
    localparam int NUM_STEPS  = 5;
    localparam int STEP_W     = 3;
    localparam int TURN_W     = 5;

    localparam logic [STEP_W-1:0] STEP_THETA = 3'd0;
    localparam logic [STEP_W-1:0] STEP_RHO   = 3'd1;
    localparam logic [STEP_W-1:0] STEP_PI    = 3'd2;
    localparam logic [STEP_W-1:0] STEP_CHI   = 3'd3;
    localparam logic [STEP_W-1:0] STEP_IOTA  = 3'd4;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_RUN_ENC    = 2'd1;
    localparam logic [1:0] ST_CLEAR_ENC  = 2'd2;
    localparam logic [1:0] ST_FINISH_ENC = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE_ENC,
        S_RUN    = ST_RUN_ENC,
        S_CLEAR  = ST_CLEAR_ENC,
        S_FINISH = ST_FINISH_ENC
    } seq_state_t;

endpackage

// File: rtl/keccak_round_sequencer_if.sv
// Bundle between the round sequencer, the five step units and the state RAM.
// STEP_WATCHDOG_EN adds the sticky err flag.
interface keccak_round_sequencer_if;
    import keccak_pkg::*;

    logic                        start;
    logic                        done;
    logic [TURN_W-1:0]           turn;
    logic [NUM_STEPS-1:0]        step_start;
    logic [NUM_STEPS-1:0]        step_rst;
    logic [NUM_STEPS-1:0]        step_done;
    logic [NUM_STEPS*ADDR_W-1:0] step_mem_adr;
    logic [NUM_STEPS*LANE_W-1:0] step_mem_in;
    logic [NUM_STEPS-1:0]        step_mem_r;
    logic [NUM_STEPS-1:0]        step_mem_w;
    logic [ADDR_W-1:0]           mem_adr;
    logic [LANE_W-1:0]           mem_in;
    logic                        mem_r;
    logic                        mem_w;
`ifdef STEP_WATCHDOG_EN
    logic                        err;
`endif

    modport master (
        input  start, step_done, step_mem_adr, step_mem_in, step_mem_r, step_mem_w,
`ifdef STEP_WATCHDOG_EN
        output err,
`endif
        output done, turn, step_start, step_rst, mem_adr, mem_in, mem_r, mem_w
    );

    modport slave (
        output start, step_done, step_mem_adr, step_mem_in, step_mem_r, step_mem_w,
`ifdef STEP_WATCHDOG_EN
        input  err,
`endif
        input  done, turn, step_start, step_rst, mem_adr, mem_in, mem_r, mem_w
    );

endinterface

// File: rtl/keccak_mem_arbiter.sv
// Combinational grant mux: forwards only the selected step unit's memory
// request to the shared state RAM, and nothing when not enabled.
module keccak_mem_arbiter
    import keccak_pkg::*;
(
    input  logic [STEP_W-1:0]           i_sel,
    input  logic                        i_en,
    input  logic [NUM_STEPS*ADDR_W-1:0] i_adr,
    input  logic [NUM_STEPS*LANE_W-1:0] i_in,
    input  logic [NUM_STEPS-1:0]        i_r,
    input  logic [NUM_STEPS-1:0]        i_w,
    output logic [ADDR_W-1:0]           o_adr,
    output logic [LANE_W-1:0]           o_in,
    output logic                        o_r,
    output logic                        o_w
);

    always_comb begin
        o_adr = '0;
        o_in  = '0;
        o_r   = 1'b0;
        o_w   = 1'b0;
        if (i_en && (int'(i_sel) < NUM_STEPS)) begin
            o_adr = i_adr[int'(i_sel)*ADDR_W +: ADDR_W];
            o_in  = i_in[int'(i_sel)*LANE_W +: LANE_W];
            o_r   = i_r[i_sel];
            o_w   = i_w[i_sel];
        end
    end

endmodule

// File: rtl/keccak_round_sequencer.sv
// Keccak-f[1600] round sequencer: walks theta..iota over 24 rounds and grants
// the state RAM to the active unit. STEP_WATCHDOG_EN adds a per-step timeout.
module keccak_round_sequencer
    import keccak_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    keccak_round_sequencer_if.master bus
);

    localparam logic [NUM_STEPS-1:0] ONE_HOT0 = {{(NUM_STEPS-1){1'b0}}, 1'b1};

    seq_state_t           r_state, w_state_nxt;
    logic [STEP_W-1:0]    r_step, w_step_nxt;
    logic [TURN_W-1:0]    r_turn, w_turn_nxt;
    logic                 r_done;
    logic [NUM_STEPS-1:0] w_onehot, w_start, w_clr;

`ifdef STEP_WATCHDOG_EN
    logic [15:0] r_wd;
    logic        r_err;
    logic        w_wd_expire;
    logic        w_stray;

    // Counter sits at zero outside RUN, so every RUN entry starts fresh.
    assign w_wd_expire = (r_state == S_RUN) && (r_wd == 16'hFFFE);
    assign w_stray     = (r_state == S_RUN) && |(bus.step_done & ~w_onehot);
`endif

    assign w_onehot = ONE_HOT0 << r_step;

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_turn_nxt  = r_turn;
        w_start     = '0;
        w_clr       = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_step_nxt  = STEP_THETA;
                    w_turn_nxt  = '0;
                end
            end
            S_RUN: begin
                w_start = w_onehot;
                if (bus.step_done[r_step]) begin
                    w_state_nxt = S_CLEAR;
                end
`ifdef STEP_WATCHDOG_EN
                else if (w_wd_expire) begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = STEP_THETA;
                    w_turn_nxt  = '0;
                end
`endif
            end
            S_CLEAR: begin
                w_clr = w_onehot;
                if (r_step < STEP_W'(NUM_STEPS-1)) begin
                    w_step_nxt  = r_step + 3'd1;
                    w_state_nxt = S_RUN;
                end else if (r_turn < TURN_W'(NUM_ROUNDS-1)) begin
                    w_step_nxt  = STEP_THETA;
                    w_turn_nxt  = r_turn + 5'd1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_turn_nxt  = '0;
                w_step_nxt  = STEP_THETA;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = STEP_THETA;
                w_turn_nxt  = '0;
            end
        endcase
    end

    // done is registered off FINISH, so it lands in the first IDLE cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_step  <= STEP_THETA;
            r_turn  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_turn  <= w_turn_nxt;
            r_done  <= (r_state == S_FINISH);
        end
    end

`ifdef STEP_WATCHDOG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd  <= (r_state == S_RUN) ? r_wd + 16'd1 : 16'd0;
            r_err <= r_err | w_stray |
                     (w_wd_expire && !bus.step_done[r_step]);
        end
    end

    assign bus.err = r_err;
`endif

    assign bus.done       = r_done;
    assign bus.turn       = r_turn;
    assign bus.step_start = w_start;
    assign bus.step_rst   = w_clr | {NUM_STEPS{reset}};

    keccak_mem_arbiter u_arb (
        .i_sel (r_step),
        .i_en  (r_state == S_RUN),
        .i_adr (bus.step_mem_adr),
        .i_in  (bus.step_mem_in),
        .i_r   (bus.step_mem_r),
        .i_w   (bus.step_mem_w),
        .o_adr (bus.mem_adr),
        .o_in  (bus.mem_in),
        .o_r   (bus.mem_r),
        .o_w   (bus.mem_w)
    );

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Bench for keccak_round_sequencer: stub step units with fixed latency, a
// timeline model derived from the per-step cost, plus directed checks.
module tb_keccak_round_sequencer;
    import keccak_pkg::*;

    localparam int L   = 3;
    localparam int SP  = L + 2;
    localparam int TOT = NUM_ROUNDS * NUM_STEPS * SP;

    logic clock = 1'b0;
    logic reset = 1'b1;

    keccak_round_sequencer_if bus();

    keccak_round_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stub step units: done rises L cycles after start rises, sticky until step_rst.
    int                   s_cnt [NUM_STEPS];
    logic [NUM_STEPS-1:0] s_done = '0;
    logic [NUM_STEPS-1:0] stray  = '0;
    logic [NUM_STEPS-1:0] hang   = '0;

    always @(posedge clock) begin
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (bus.step_rst[i]) begin
                s_cnt[i]  <= 0;
                s_done[i] <= 1'b0;
            end else if (bus.step_start[i] && !s_done[i] && !hang[i]) begin
                if (s_cnt[i] == L - 1) s_done[i] <= 1'b1;
                else                   s_cnt[i]  <= s_cnt[i] + 1;
            end
        end
    end

    int          adr_tab [NUM_STEPS] = '{3, 7, 9, 20, 12};
    logic [4:0]  r_tab = 5'b10110;
    logic [4:0]  w_tab = 5'b00011;

    assign bus.step_done    = s_done | stray;
    assign bus.step_mem_adr = {5'd12, 5'd20, 5'd9, 5'd7, 5'd3};
    assign bus.step_mem_in  = {64'hA5A5_0000_0000_0004, 64'hA5A5_0000_0000_0003,
                               64'hA5A5_0000_0000_0002, 64'hA5A5_0000_0000_0001,
                               64'hA5A5_0000_0000_0000};
    assign bus.step_mem_r   = r_tab;
    assign bus.step_mem_w   = w_tab;

    // Timeline model: a run is just elapsed cycles since start was accepted.
    int cyc    = 0;
    int m_s    = 0;
    bit m_busy = 1'b0;
    bit chk_en = 1'b1;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
        end else begin
            if ((!m_busy || (cyc - m_s >= TOT + 1)) && bus.start) begin
                m_busy <= 1'b1;
                m_s    <= cyc + 1;
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            int e, k, ph, g;
            logic [4:0]  ex_ss, ex_rst, ex_turn;
            logic        ex_done;
            e = cyc - m_s;
            g = -1;
            ex_ss = '0; ex_rst = '0; ex_turn = '0; ex_done = 1'b0;
            if (reset) begin
                ex_rst = '1;
            end else if (m_busy && e < TOT) begin
                k  = e / SP;
                ph = e % SP;
                ex_turn = 5'(k / NUM_STEPS);
                if (ph <= L) begin
                    ex_ss = 5'(1) << (k % NUM_STEPS);
                    g = k % NUM_STEPS;
                end else begin
                    ex_rst = 5'(1) << (k % NUM_STEPS);
                end
            end else if (m_busy && e == TOT) begin
                ex_turn = 5'(NUM_ROUNDS - 1);
            end else if (m_busy && e == TOT + 1) begin
                ex_done = 1'b1;
            end
            chk("step_start", 64'(bus.step_start), 64'(ex_ss));
            chk("step_rst",   64'(bus.step_rst),   64'(ex_rst));
            chk("turn",       64'(bus.turn),       64'(ex_turn));
            chk("done",       64'(bus.done),       64'(ex_done));
            chk("mem_r",   64'(bus.mem_r),   (g < 0) ? 64'd0 : 64'(r_tab[g]));
            chk("mem_w",   64'(bus.mem_w),   (g < 0) ? 64'd0 : 64'(w_tab[g]));
            chk("mem_adr", 64'(bus.mem_adr), (g < 0) ? 64'd0 : 64'(adr_tab[g]));
            chk("mem_in",  bus.mem_in, (g < 0) ? 64'd0 : (64'hA5A5_0000_0000_0000 | 64'(g)));
        end
    end

    task automatic run_start();
        bus.start = 1'b1;
        @(posedge clock); #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!bus.done && n < 2000);
    endtask

    task automatic wait_for(input logic [4:0] turn_v, input logic [4:0] ss_v, input string nm);
        int  n;
        bit  hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 2000) begin
            @(posedge clock); #1;
            n++;
            hit = (bus.turn == turn_v) && (bus.step_start == ss_v);
        end
        chk(nm, 64'(hit), 64'd1);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_step_rst", 64'(bus.step_rst), 64'h1F);
        reset = 1'b0;
        #1;
        chk("rst_turn", 64'(bus.turn), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_step_start", 64'(bus.step_start), 64'd0);

        // Single permutation, L=3: 120 steps of 5 cycles, done 601 after accept
        run_start();
        #1;
        chk("first_step_start", 64'(bus.step_start), 64'h01);
        wait_done(n);
        chk("latency", 64'(n), 64'd601);
        @(posedge clock); #1;
        chk("done_one_cycle", 64'(bus.done), 64'd0);

        // Grant: iota reads adr 12 while theta's write stays blocked
        run_start();
        wait_for(5'd0, 5'b10000, "reach_iota");
        chk("iota_mem_r",   64'(bus.mem_r),   64'd1);
        chk("iota_mem_adr", 64'(bus.mem_adr), 64'd12);
        chk("iota_mem_w",   64'(bus.mem_w),   64'd0);

        // Reset at round 7 step 2
        wait_for(5'd7, 5'b00100, "reach_r7s2");
        reset = 1'b1;
        #1;
        chk("midrst_step_rst", 64'(bus.step_rst), 64'h1F);
        chk("midrst_mem_r",    64'(bus.mem_r),    64'd0);
        chk("midrst_mem_w",    64'(bus.mem_w),    64'd0);
        chk("midrst_turn",     64'(bus.turn),     64'd0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock); #2;

        // Restart with start pulses and stray rho done during chi
        run_start();
        wait_for(5'd2, 5'b01000, "reach_r2s3");
        stray     = 5'b00010;
        bus.start = 1'b1;
        @(posedge clock); #2;
        @(posedge clock); #2;
        stray     = 5'b00000;
        bus.start = 1'b0;
        begin
            int n2;
            wait_done(n2);
            n = n2 + 0;
        end
        chk("stray_turn_done", 64'(bus.done), 64'd1);
        @(posedge clock); #2;

        // start held across FINISH chains a second permutation
        bus.start = 1'b1;
        @(posedge clock); #2;
        wait_done(n);
        chk("held_latency", 64'(n), 64'd601);
        @(posedge clock); #1;
        chk("chain_step_start", 64'(bus.step_start), 64'h01);
        chk("chain_turn",       64'(bus.turn),       64'd0);
        #1;
        bus.start = 1'b0;
        wait_done(n);
        chk("chain_latency", 64'(n), 64'd601);
        @(posedge clock); #2;

`ifdef STEP_WATCHDOG_EN
        begin
            int  w;
            bit  done_seen;
            chk_en = 1'b0;
            reset = 1'b1;
            @(posedge clock); #2;
            reset = 1'b0;
            hang = 5'b01000;
            run_start();
            wait_for(5'd0, 5'b01000, "reach_chi");
            w = 1;
            done_seen = 1'b0;
            while (!bus.err && w < 70000) begin
                @(posedge clock); #1;
                done_seen = done_seen | bus.done;
                if (!bus.err) w++;
            end
            chk("wd_err",        64'(bus.err),        64'd1);
            chk("wd_cycles",     64'(w),              64'd65535);
            chk("wd_no_done",    64'(done_seen),      64'd0);
            chk("wd_step_start", 64'(bus.step_start), 64'd0);
            chk("wd_mem_r",      64'(bus.mem_r),      64'd0);
            hang = '0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/keccak_round_sequencer.md
Name: keccak_round_sequencer

Overview:
Top-level scheduler for the Keccak-f[1600] permutation core. It sequences the five step units (theta, rho, pi, chi, iota/addrc) over 24 rounds and drives each unit's start/turn. It also arbitrates the single shared 25-lane state memory so only the active step unit reaches it. It sits between the hash front-end (start/done) and the step units plus the state RAM.

Parameters:
NUM_ROUNDS, 24, rounds per permutation; turn counts 0..NUM_ROUNDS-1
NUM_STEPS, 5, step units in fixed order 0=theta 1=rho 2=pi 3=chi 4=iota
ADDR_W, 5, lane address width
LANE_W, 64, lane width

Ports:
clock  in  1  system clock, posedge
reset  in  1  asynchronous, active-high
start  in  1  level request to run one permutation
done  out  1  one-cycle pulse when permutation finished
turn  out  5  current round index, to step units
step_start  out  NUM_STEPS  one-hot start, level held while step runs
step_rst  out  NUM_STEPS  per-unit clear, since unit done flags are sticky
step_done  in  NUM_STEPS  per-unit done flags
step_mem_adr  in  NUM_STEPS*ADDR_W  flattened unit addresses, unit i at [i*ADDR_W +: ADDR_W]
step_mem_in  in  NUM_STEPS*LANE_W  flattened unit write data
step_mem_r  in  NUM_STEPS  unit read enables
step_mem_w  in  NUM_STEPS  unit write enables
mem_adr  out  ADDR_W  to state RAM
mem_in  out  LANE_W  to state RAM
mem_r  out  1  to state RAM
mem_w  out  1  to state RAM

Behaviour:
- One clock, named clock. Reset is asynchronous and active-high, named reset.
- States: IDLE, RUN, CLEAR, FINISH. The state, step index (3b), round counter (5b) and done are registers.
- On reset: state=IDLE, step=0, turn=0, done=0, step_start=0.
- step_rst is all ones while reset is high.
- IDLE:
  - start=1 moves to RUN with step=0, turn=0.
  - start=0 stays in IDLE.
- RUN:
  - step_start[step]=1, all other bits 0.
  - The shared memory is granted to unit step.
  - When step_done[step] is sampled high, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - step_start=0 and step_rst[step]=1.
  - If step<NUM_STEPS-1: step++ and return to RUN.
  - Else if turn<NUM_ROUNDS-1: step=0, turn++, return to RUN.
  - Else go to FINISH.
- FINISH:
  - done=1 for 1 cycle, turn resets to 0, go to IDLE.
  - A new permutation starts only from IDLE; start held high across FINISH starts the next run immediately.
- Memory mux (combinational from state/step):
  - In RUN, mem_* = unit[step] signals.
  - In IDLE, CLEAR and FINISH, mem_r=mem_w=0, mem_adr=0, mem_in=0.
  - Requests from non-granted units are ignored, never forwarded.
- Latency: each step costs L+2 cycles, where L = cycles from the step_start rise to the step_done rise. done asserts NUM_ROUNDS*NUM_STEPS*(L+2)+1 cycles after start is sampled.
- Boundary conditions:
  - start toggling while busy: ignored.
  - step_done of a non-active unit: ignored.
  - Active unit's step_done already high on RUN entry: advance after 1 RUN cycle.
  - Reset mid-run: immediate return to IDLE, all units cleared via step_rst, memory deselected.
- turn is stable for the whole of each round and changes only in the CLEAR of step 4.

Optional Feature:
STEP_WATCHDOG_EN:
- With the macro: adds a 16-bit cycle counter, cleared on RUN entry. If the counter reaches 16'hFFFF in RUN, the sequencer asserts output err (sticky until reset) and goes to IDLE without pulsing done. Stray step_done from a non-active unit also sets err.
- Without the macro: no err port and no counter; the sequencer waits indefinitely.

Decomposition:
- Shared package keccak_pkg holds:
  - LANE_W, ADDR_W, NUM_ROUNDS, NUM_STEPS;
  - step index constants STEP_THETA..STEP_IOTA;
  - state encoding localparams.
- One natural sub-module, keccak_mem_arbiter: the combinational grant mux selecting unit signals by step index plus a valid enable.

Test Plan:
1. Reset, then start=1 with stub units, L=3 -> step_start walks 00001,00010,00100,01000,10000 per round. turn goes 0..23. done pulses once, 601 cycles after start is sampled.
2. Stub iota issues mem_r, adr=12 -> mem_r=1, mem_adr=12 only while step=4. Theta stub driving mem_w concurrently -> mem_w=0.
3. Assert reset at round 7, step 2 -> next cycle state IDLE, turn=0, step_rst=11111 during reset, mem_r=mem_w=0. A restart then completes normally.
4. Pulse start mid-run, plus stray step_done[1] during step 3 -> no restart, no early advance, done timing unchanged.
5. Hold start high after done -> second permutation begins the cycle after IDLE is re-entered, turn restarts at 0.
6. STEP_WATCHDOG_EN defined, chi stub never finishes -> err=1 after 65535 RUN cycles, done stays 0, state IDLE.
